// File: rtl/prio_enc_pkg.sv
// Shared helpers for the prio_event_encoder block: index-width computation
// and index-to-onehot conversion.
package prio_enc_pkg;

  // Widest event vector the onehot helper can produce; callers size-cast
  // the result down to their own N.
  localparam int MAX_N = 1024;

  // Bits needed to hold an index in 0..n-1 (at least 1).
  function automatic int clog2_f(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [MAX_N-1:0] onehot_f(input int unsigned idx);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational search for the first set bit of vec, scanning downward from
// base and wrapping from 0 back to N-1. Fixed priority ties base to N-1.
module prio_find_first
  import prio_enc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = clog2_f(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  // Walk from the farthest position toward base so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(base) - k;
      if (j < 0) j = j + N;
      if (vec[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Registered priority encoder with event capture. Event pulses latch into a
// pending register; the best unmasked pending index is offered on a
// valid/ready port and its bit clears on acceptance.
// Optional macro ROTATE_PRIORITY_EN: round-robin priority instead of fixed
// highest-index-wins.
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = clog2_f(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] evt_in,
  input  logic [N-1:0] mask,
  input  logic         clr_all,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] pending_reg;
  logic         out_valid_reg;
  logic [W-1:0] out_idx_reg;
  logic         overflow_reg;

  logic         acc;
  logic [N-1:0] acc_vec;
  logic [N-1:0] cand;
  logic [W-1:0] search_base;
  logic         found;
  logic [W-1:0] found_idx;

  assign acc     = out_valid_reg & out_ready;
  assign acc_vec = acc ? N'(onehot_f(32'(out_idx_reg))) : '0;
  // The line being accepted is never re-offered from the old pending value.
  assign cand    = pending_reg & ~mask & ~acc_vec;

`ifdef ROTATE_PRIORITY_EN
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_eff;

  // An accept this cycle already makes the accepted line lowest priority.
  assign ptr_eff     = acc ? out_idx_reg : ptr_reg;
  assign search_base = (ptr_eff == '0) ? W'(N - 1) : ptr_eff - 1'b1;

  // Rotation pointer follows the most recently accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= W'(N - 1);
    end else if (!clr_all && acc) begin
      ptr_reg <= out_idx_reg;
    end
  end
`else
  assign search_base = W'(N - 1);
`endif

  prio_find_first #(.N(N)) u_find (
    .vec   (cand),
    .base  (search_base),
    .found (found),
    .idx   (found_idx)
  );

  // Pending capture, overflow detect and output stage; clr_all overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      overflow_reg  <= 1'b0;
    end else if (clr_all) begin
      pending_reg   <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      pending_reg  <= (pending_reg & ~acc_vec) | evt_in;
      overflow_reg <= |(evt_in & pending_reg & ~acc_vec);
      if (!out_valid_reg || acc) begin
        out_valid_reg <= found;
        if (found) out_idx_reg <= found_idx;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed self-checking bench for prio_event_encoder (N=16).
module tb_prio_event_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] evt_in;
  logic [15:0] mask;
  logic        clr_all;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [15:0] pending;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  prio_event_encoder #(.N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .evt_in    (evt_in),
    .mask      (mask),
    .clr_all   (clr_all),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs
  // changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_in = '0; mask = '0; clr_all = 1'b0; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0 || overflow !== 1'b0 || out_idx !== 4'd0) begin failures++; $display("FAIL reset_init got v=%b idx=%0d p=%h ov=%b exp all 0", out_valid, out_idx, pending, overflow); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // load 0x00F0 with no consumer
    evt_in = 16'h00F0;
    tick();
    evt_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd7 || pending !== 16'h00F0) begin failures++; $display("FAIL reset_pre got v=%b idx=%0d p=%h exp v=1 idx=7 p=00f0", out_valid, out_idx, pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0 || out_idx !== 4'd0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_async got v=%b idx=%0d p=%h ov=%b exp all 0", out_valid, out_idx, pending, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0 || out_idx !== 4'd0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_after got v=%b idx=%0d p=%h ov=%b exp all 0", out_valid, out_idx, pending, overflow); end
    $display("txn reset done");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    evt_in = 16'h0001;
    tick();
    evt_in = '0;
    checks++; if (pending !== 16'h0001 || out_valid !== 1'b0) begin failures++; $display("FAIL single_pend got p=%h v=%b exp p=0001 v=0", pending, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0) begin failures++; $display("FAIL single_out got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx); end
    $display("txn single idx=%0d", out_idx);
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0) begin failures++; $display("FAIL single_done got v=%b p=%h exp v=0 p=0000", out_valid, pending); end
  endtask

  task automatic test_burst();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'd15; exp_seq[1] = 4'd10; exp_seq[2] = 4'd5; exp_seq[3] = 4'd0;
    out_ready = 1'b1;
    evt_in = 16'h8421;
    tick();
    evt_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== exp_seq[i]) begin failures++; $display("FAIL burst_%0d got v=%b idx=%0d exp v=1 idx=%0d", i, out_valid, out_idx, exp_seq[i]); end
      $display("txn burst idx=%0d", out_idx);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0) begin failures++; $display("FAIL burst_end got v=%b p=%h exp v=0 p=0000", out_valid, pending); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    evt_in = 16'h0010;
    tick();
    evt_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd4) begin failures++; $display("FAIL bp_first got v=%b idx=%0d exp v=1 idx=4", out_valid, out_idx); end
    evt_in = 16'h4000;
    tick();
    evt_in = '0;
    checks++; if (pending !== 16'h4010) begin failures++; $display("FAIL bp_pend got p=%h exp p=4010", pending); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd4) begin failures++; $display("FAIL bp_hold got v=%b idx=%0d exp v=1 idx=4", out_valid, out_idx); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd14 || pending !== 16'h4000) begin failures++; $display("FAIL bp_next got v=%b idx=%0d p=%h exp v=1 idx=14 p=4000", out_valid, out_idx, pending); end
    $display("txn back_pressure idx=%0d", out_idx);
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0) begin failures++; $display("FAIL bp_end got v=%b p=%h exp v=0 p=0000", out_valid, pending); end
  endtask

  task automatic test_mask();
    out_ready = 1'b1;
    mask = 16'h8000;
    evt_in = 16'h8001;
    tick();
    evt_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0) begin failures++; $display("FAIL mask_low got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h8000) begin failures++; $display("FAIL mask_hold got v=%b p=%h exp v=0 p=8000", out_valid, pending); end
    mask = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd15) begin failures++; $display("FAIL mask_release got v=%b idx=%0d exp v=1 idx=15", out_valid, out_idx); end
    $display("txn mask idx=%0d", out_idx);
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0) begin failures++; $display("FAIL mask_end got v=%b p=%h exp v=0 p=0000", out_valid, pending); end
  endtask

  task automatic test_overflow_flush();
    out_ready = 1'b0;
    evt_in = 16'h0004;
    tick();
    checks++; if (overflow !== 1'b0 || pending !== 16'h0004) begin failures++; $display("FAIL ovf_first got ov=%b p=%h exp ov=0 p=0004", overflow, pending); end
    tick();
    evt_in = '0;
    checks++; if (overflow !== 1'b1 || out_valid !== 1'b1 || out_idx !== 4'd2) begin failures++; $display("FAIL ovf_pulse got ov=%b v=%b idx=%0d exp ov=1 v=1 idx=2", overflow, out_valid, out_idx); end
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got ov=%b exp ov=0", overflow); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0) begin failures++; $display("FAIL ovf_single got v=%b p=%h exp v=0 p=0000", out_valid, pending); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_nodup got v=%b exp v=0", out_valid); end
    $display("txn overflow idx=2 merged");
    out_ready = 1'b0;
    evt_in = 16'h0008;
    tick();
    evt_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd3) begin failures++; $display("FAIL flush_pre got v=%b idx=%0d exp v=1 idx=3", out_valid, out_idx); end
    clr_all = 1'b1; evt_in = 16'h0002; out_ready = 1'b1;
    tick();
    clr_all = 1'b0; evt_in = '0;
    checks++; if (pending !== 16'h0 || out_valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL flush got p=%h v=%b ov=%b exp p=0000 v=0 ov=0", pending, out_valid, overflow); end
    tick();
    checks++; if (pending !== 16'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_after got p=%h v=%b exp p=0000 v=0", pending, out_valid); end
    $display("txn flush done");
  endtask

`ifdef ROTATE_PRIORITY_EN
  task automatic test_rotate();
    logic [3:0] exp_idx;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    evt_in = 16'hFFFF;
    tick();
    exp_idx = 4'd14;
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== exp_idx) begin failures++; $display("FAIL rotate_%0d got v=%b idx=%0d exp v=1 idx=%0d", i, out_valid, out_idx, exp_idx); end
      $display("txn rotate idx=%0d", out_idx);
      exp_idx = exp_idx - 4'd1;
    end
    evt_in = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_back_pressure();
    test_mask();
    test_overflow_flush();
`ifdef ROTATE_PRIORITY_EN
    test_rotate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
